tick_scheduler: RTL and testbench

//  Shared timebase controller: one free-running prescaler divides clk_50MHz to a base tick,
//  and NCH independent channels count base ticks to produce programmable periodic or one-shot

---
 rtl/tick_scheduler_pkg.sv | 17 +
 rtl/tick_scheduler_channel.sv | 98 +++++++++
 rtl/tick_scheduler.sv | 92 +++++++++
 tb/tb_tick_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_scheduler_pkg.sv
// Shared types and helpers for the tick scheduler: channel FSM states,
// channel mode encodings and the prescaler divide-ratio calculation.
package tick_scheduler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    function automatic int prescale_div(input int clk_hz, input int base_hz);
        return clk_hz / base_hz;
    endfunction

endpackage

// File: rtl/tick_scheduler_channel.sv
// One scheduler channel: counts base ticks down from its period register and
// emits a tick pulse, a square wave and a sticky one-shot done flag.
module tick_channel
    import tick_scheduler_pkg::*;
#(
    parameter int PW         = 16,
    parameter int DEF_PERIOD = 1000
) (
    input  logic          clk_50MHz,
    input  logic          rst,
    input  logic          base_tick,
    input  logic          start,
    input  logic          stop,
    input  logic          done_clr,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_period,
    input  logic          cfg_mode,
    output logic          run,
    output logic          tick,
    output logic          sqw,
    output logic          done
);

    ch_state_e     state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] period_q, period_d;
    logic          mode_q, mode_d;
    logic          tick_q, tick_d;
    logic          sqw_q, sqw_d;
    logic          done_q, done_d;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= PW'(DEF_PERIOD);
            mode_q   <= MODE_PERIODIC;
            tick_q   <= 1'b0;
            sqw_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            sqw_q    <= sqw_d;
            done_q   <= done_d;
        end
    end

    // Start and reload read period_q/mode_q, so a same-cycle config write only
    // takes effect at the following reload or expiry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        sqw_d    = sqw_q;
        done_d   = done_clr ? 1'b0 : done_q;

        if (cfg_we) begin
            period_d = cfg_period;
            mode_d   = cfg_mode;
        end

        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sqw_d   = 1'b0;
        end else if (start) begin
            state_d = ST_RUN;
            cnt_d   = period_q;
            done_d  = 1'b0;
        end else if (state_q == ST_RUN && base_tick) begin
            if (cnt_q > PW'(1)) begin
                cnt_d = cnt_q - PW'(1);
            end else begin
                tick_d = 1'b1;
                sqw_d  = ~sqw_q;
                if (mode_q == MODE_ONESHOT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = period_q;
                end
            end
        end
    end

    assign run  = (state_q == ST_RUN);
    assign tick = tick_q;
    assign sqw  = sqw_q;
    assign done = done_q;

endmodule

// File: rtl/tick_scheduler.sv
// Shared timebase: a free-running prescaler producing base_tick, configuration
// decode with error reporting, and NCH independent tick channels.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BASE_HZ    = 1000,
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int PW         = 16,
    parameter int DEF_PERIOD = 1000
) (
    input  logic           clk_50MHz,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [PW-1:0]  cfg_period,
    input  logic           cfg_mode,
    input  logic [NCH-1:0] start,
    input  logic [NCH-1:0] stop,
    input  logic [NCH-1:0] done_clr,
    output logic           cfg_err,
    output logic           base_tick,
    output logic [NCH-1:0] run,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sqw,
    output logic [NCH-1:0] done
);

    localparam int DIV = prescale_div(CLK_HZ, BASE_HZ);
    localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PSW-1:0] presc_q, presc_d;
    logic           base_tick_q, base_tick_d;
    logic           cfg_err_q, cfg_err_d;
    logic           cfg_ok;
    logic [NCH-1:0] cfg_sel;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            base_tick_q <= base_tick_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // The prescaler never sees channel activity, so every channel shares one phase.
    always_comb begin
        presc_d     = presc_q + PSW'(1);
        base_tick_d = 1'b0;
        if (presc_q == PSW'(DIV - 1)) begin
            presc_d     = '0;
            base_tick_d = 1'b1;
        end

        cfg_ok    = cfg_we && (cfg_period != '0) && (32'(cfg_ch) < NCH);
        cfg_err_d = cfg_we && !cfg_ok;
        cfg_sel   = '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_sel[i] = cfg_ok && (32'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tick_channel #(
            .PW         (PW),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_channel (
            .clk_50MHz  (clk_50MHz),
            .rst        (rst),
            .base_tick  (base_tick_q),
            .start      (start[g]),
            .stop       (stop[g]),
            .done_clr   (done_clr[g]),
            .cfg_we     (cfg_sel[g]),
            .cfg_period (cfg_period),
            .cfg_mode   (cfg_mode),
            .run        (run[g]),
            .tick       (tick[g]),
            .sqw        (sqw[g]),
            .done       (done[g])
        );
    end

    assign base_tick = base_tick_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: a scoreboard of expected tick and
// cfg_err events (edge number, channel, square-wave level) plus level checks.
module tb_tick_scheduler;

    localparam int NCH        = 4;
    localparam int CHW        = 2;
    localparam int PW         = 16;
    localparam int DEF_PERIOD = 5;
    localparam int DIV        = 20;

    logic           clk_50MHz = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [PW-1:0]  cfg_period = '0;
    logic           cfg_mode = 1'b0;
    logic [NCH-1:0] start = '0;
    logic [NCH-1:0] stop = '0;
    logic [NCH-1:0] done_clr = '0;
    logic           cfg_err;
    logic           base_tick;
    logic [NCH-1:0] run;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sqw;
    logic [NCH-1:0] done;

    typedef struct {
        int   kind;
        int   ch;
        int   cyc;
        logic sqw;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        cyc;
    int        n_checks = 0;
    int        n_errors = 0;

    tick_scheduler #(
        .CLK_HZ     (20),
        .BASE_HZ    (1),
        .NCH        (NCH),
        .CHW        (CHW),
        .PW         (PW),
        .DEF_PERIOD (DEF_PERIOD)
    ) dut (
        .clk_50MHz  (clk_50MHz),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .stop       (stop),
        .done_clr   (done_clr),
        .cfg_err    (cfg_err),
        .base_tick  (base_tick),
        .run        (run),
        .tick       (tick),
        .sqw        (sqw),
        .done       (done)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    // Edge counter since the last reset release; the prescaler value equals cyc % DIV.
    always @(posedge clk_50MHz or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic we, input int ch, input int period, input logic mode,
                                 input logic [NCH-1:0] st, input logic [NCH-1:0] sp,
                                 input logic [NCH-1:0] dc, output int s_edge);
        cfg_we     = we;
        cfg_ch     = CHW'(ch);
        cfg_period = PW'(period);
        cfg_mode   = mode;
        start      = st;
        stop       = sp;
        done_clr   = dc;
        s_edge     = cyc + 1;
        @(negedge clk_50MHz);
        cfg_we   = 1'b0;
        start    = '0;
        stop     = '0;
        done_clr = '0;
    endtask

    task automatic pushEvent(input int kind, input int ch, input int c, input logic sq);
        sb_entry_t e;
        e.kind = kind;
        e.ch   = ch;
        e.cyc  = c;
        e.sqw  = sq;
        sb.push_back(e);
    endtask

    task automatic scoreEvent(input int kind, input int ch, input logic sq);
        sb_entry_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_unexpected_event", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("sb_event", 32'((kind << 28) | (ch << 24) | cyc),
                        32'((e.kind << 28) | (e.ch << 24) | e.cyc));
            if (kind == 0) checkOutput("sb_sqw", 32'(sq), 32'(e.sqw));
        end
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk_50MHz);
    endtask

    // First edge strictly after start edge s at which a channel sees base_tick high.
    function automatic int next_bt(input int s);
        int k;
        k = (s + DIV - 1) / DIV;
        if (k < 1) k = 1;
        return k * DIV + 1;
    endfunction

    always @(negedge clk_50MHz) begin
        if (!rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (tick[ch]) scoreEvent(0, ch, sqw[ch]);
            end
            if (cfg_err) scoreEvent(1, 0, 1'b0);
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete, edge %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int e1;

        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        checkOutput("reset_outputs", 32'({run, tick, sqw, done, cfg_err, base_tick}), 32'd0);
        #2 rst = 1'b0;

        for (int i = 0; i < 45; i++) begin
            @(negedge clk_50MHz);
            checkOutput("base_tick", 32'(base_tick), 32'((cyc % DIV == 0) && (cyc > 0)));
        end

        $display("[TB] channel 0 periodic, period 3");
        applyStimulus(1'b1, 0, 3, 1'b0, '0, '0, '0, s);
        applyStimulus(1'b0, 0, 0, 1'b0, 4'b0001, '0, '0, s);
        e1 = next_bt(s) + DIV * 2;
        pushEvent(0, 0, e1, 1'b1);
        pushEvent(0, 0, e1 + 3 * DIV, 1'b0);
        pushEvent(0, 0, e1 + 6 * DIV, 1'b1);
        checkOutput("ch0_run", 32'(run), 32'b0001);
        waitUntil(e1 + 6 * DIV + 9);
        applyStimulus(1'b0, 0, 0, 1'b0, '0, 4'b0001, '0, s);
        checkOutput("ch0_stopped", 32'({run[0], sqw[0]}), 32'd0);
        waitUntil(e1 + 9 * DIV + 5);

        $display("[TB] channel 1 one-shot, period 2");
        applyStimulus(1'b1, 1, 2, 1'b1, '0, '0, '0, s);
        applyStimulus(1'b0, 0, 0, 1'b0, 4'b0010, '0, '0, s);
        e1 = next_bt(s) + DIV;
        pushEvent(0, 1, e1, 1'b1);
        checkOutput("ch1_run", 32'(run), 32'b0010);
        waitUntil(e1 - 1);
        checkOutput("ch1_pre_expiry", 32'({run[1], done[1]}), 32'b10);
        waitUntil(e1);
        checkOutput("ch1_expired", 32'({run[1], done[1]}), 32'b01);
        waitUntil(e1 + 3 * DIV);
        checkOutput("ch1_done_sticky", 32'({run[1], done[1]}), 32'b01);
        applyStimulus(1'b0, 0, 0, 1'b0, '0, '0, 4'b0010, s);
        checkOutput("ch1_done_clr", 32'(done[1]), 32'd0);

        applyStimulus(1'b0, 0, 0, 1'b0, 4'b0010, '0, '0, s);
        e1 = next_bt(s) + DIV;
        pushEvent(0, 1, e1, 1'b0);
        waitUntil(e1 - 1);
        applyStimulus(1'b0, 0, 0, 1'b0, '0, '0, 4'b0010, s);
        checkOutput("ch1_set_beats_clr", 32'(done[1]), 32'd1);

        $display("[TB] channel 2 rejected write then default period");
        pushEvent(1, 0, cyc + 1, 1'b0);
        applyStimulus(1'b1, 2, 0, 1'b1, '0, '0, '0, s);
        waitUntil(s + 3);
        applyStimulus(1'b0, 0, 0, 1'b0, 4'b0100, '0, '0, s);
        e1 = next_bt(s) + DIV * (DEF_PERIOD - 1);
        pushEvent(0, 2, e1, 1'b1);
        pushEvent(0, 2, e1 + DEF_PERIOD * DIV, 1'b0);
        waitUntil(e1 + DEF_PERIOD * DIV + 9);
        checkOutput("ch2_still_running", 32'(run[2]), 32'd1);
        applyStimulus(1'b0, 0, 0, 1'b0, '0, 4'b0100, '0, s);
        checkOutput("ch2_stopped", 32'({run[2], sqw[2]}), 32'd0);

        $display("[TB] channel 3 start+stop, then write+start");
        applyStimulus(1'b0, 0, 0, 1'b0, 4'b1000, 4'b1000, '0, s);
        checkOutput("ch3_start_stop", 32'(run[3]), 32'd0);
        waitUntil(s + 2);
        applyStimulus(1'b1, 3, 2, 1'b0, 4'b1000, '0, '0, s);
        e1 = next_bt(s) + DIV * (DEF_PERIOD - 1);
        pushEvent(0, 3, e1, 1'b1);
        pushEvent(0, 3, e1 + 2 * DIV, 1'b0);
        waitUntil(e1 + 2 * DIV + 4);
        applyStimulus(1'b0, 0, 0, 1'b0, '0, 4'b1000, '0, s);
        checkOutput("ch3_stopped", 32'({run[3], sqw[3]}), 32'd0);
        waitUntil(s + 5 * DIV);

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1'b0, 0, 0, 1'b0, 4'b0101, '0, '0, s);
        waitUntil(s + 10);
        checkOutput("run_before_reset", 32'({run, done}), 32'b0101_0010);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset_outputs", 32'({run, tick, sqw, done, cfg_err, base_tick}), 32'd0);
        sb.delete();
        @(negedge clk_50MHz);
        rst = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0, 4'b0001, '0, '0, s);
        e1 = next_bt(s) + DIV * (DEF_PERIOD - 1);
        pushEvent(0, 0, e1, 1'b1);
        waitUntil(e1 + 2);
        applyStimulus(1'b0, 0, 0, 1'b0, '0, 4'b0001, '0, s);
        checkOutput("post_reset_stopped", 32'(run), 32'd0);
        waitUntil(s + 4 * DIV);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
